// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle datapath: ALU operations, mux selects,
// memory-interface states and instruction field positions.
package mc_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_INC     = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } srcb_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_A      = 2'b11
  } pcsrc_e;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_LO  = 21;
  localparam int RT_LO  = 16;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int JT_HI  = 25;
  localparam int JT_LO  = 0;

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU: eight operations modulo 2^DATA_W plus a zero flag.
module mc_alu
  import mc_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] shamt;
  assign shamt = b[SH_W-1:0];

  // NOTE: every output of an always_comb gets a default first; a path that
  // leaves it unassigned would infer a latch.
  always_comb begin
    result = '0;
    case (alu_op_e'(op))
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLL: result = a << shamt;
      ALU_SRL: result = a >> shamt;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mc_datapath_p.sv
// Multi-cycle MIPS-style datapath: PC/IR/A/B/ALUOut/MDR, register file and a
// stalling request/ack data-memory port.
module mc_datapath_p
  import mc_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter int              REG_N    = 16,
  parameter longint unsigned RESET_PC = 0,
  parameter int unsigned     PC_INC   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SelectIns,
  input  logic              RegWrite,
  input  logic              RegDst,
  input  logic              ALUSrcA,
  input  logic [1:0]        ALUSrcB,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemtoReg,
  input  logic              PCWrite,
  input  logic              BEQ,
  input  logic              BNE,
  input  logic [1:0]        PCSrc,
  input  logic [2:0]        ALUOp,
  input  logic [31:0]       instr,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic [DATA_W-1:0] pc,
  output logic [5:0]        opcode,
  output logic              alu_zero,
  output logic              busy
);

  localparam int RA_W = $clog2(REG_N);

  logic [31:0]       ir;
  logic [DATA_W-1:0] a_q, b_q, alu_out, mdr;
  logic [DATA_W-1:0] regs [REG_N];

  logic [RA_W-1:0]   rs_idx, rt_idx, rd_idx, wr_idx;
  logic [DATA_W-1:0] rs_val, rt_val, wr_data;
  logic [DATA_W-1:0] alu_a, alu_b, alu_res, imm_sext, next_pc;
  logic [63:0]       pc_wide, jump_wide;
  logic              pc_load;

  mem_state_e state, state_d;
  logic       issue;

  assign opcode = ir[OP_HI:OP_LO];
  assign rs_idx = ir[RS_LO +: RA_W];
  assign rt_idx = ir[RT_LO +: RA_W];
  assign rd_idx = ir[RD_LO +: RA_W];

  // Register 0 is hard-wired to zero on the read side as well.
  assign rs_val = (rs_idx == '0) ? '0 : regs[rs_idx];
  assign rt_val = (rt_idx == '0) ? '0 : regs[rt_idx];

  assign imm_sext = DATA_W'($signed(ir[IMM_HI:IMM_LO]));
  assign alu_a    = ALUSrcA ? a_q : pc;

  always_comb begin
    alu_b = b_q;
    case (srcb_e'(ALUSrcB))
      SRCB_REG:     alu_b = b_q;
      SRCB_INC:     alu_b = DATA_W'(PC_INC);
      SRCB_IMM:     alu_b = imm_sext;
      SRCB_IMM_SH2: alu_b = imm_sext << 2;
      default:      alu_b = b_q;
    endcase
  end

  mc_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (ALUOp),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_res),
    .zero   (alu_zero)
  );

  // Jump target is built at 64 bits so narrow datapaths simply truncate it.
  assign pc_wide   = 64'(pc);
  assign jump_wide = {pc_wide[63:28], ir[JT_HI:JT_LO], 2'b00};

  always_comb begin
    next_pc = alu_res;
    case (pcsrc_e'(PCSrc))
      PCSRC_ALU:    next_pc = alu_res;
      PCSRC_ALUOUT: next_pc = alu_out;
      PCSRC_JUMP:   next_pc = DATA_W'(jump_wide);
      PCSRC_A:      next_pc = a_q;
      default:      next_pc = alu_res;
    endcase
  end

  assign pc_load = ~busy & (PCWrite | (BEQ & alu_zero) | (BNE & ~alu_zero));
  assign wr_idx  = RegDst ? rd_idx : rt_idx;
  assign wr_data = MemtoReg ? mdr : alu_out;

  // Memory access tracker: one outstanding request, held until acknowledged.
  always_comb begin
    state_d = state;
    issue   = 1'b0;
    case (state)
      MEM_IDLE: if (MemRead | MemWrite) begin
        state_d = MEM_WAIT;
        issue   = 1'b1;
      end
      MEM_WAIT: if (dmem_ack) state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
  end

  assign busy     = (state == MEM_WAIT);
  assign dmem_req = busy;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= MEM_IDLE;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      mdr        <= '0;
    end else begin
      state <= state_d;
      if (issue) begin
        dmem_we    <= MemWrite;
        dmem_addr  <= alu_out;
        dmem_wdata <= b_q;
      end
      if (busy && dmem_ack && !dmem_we) mdr <= dmem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= DATA_W'(RESET_PC);
      ir      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_out <= '0;
    end else if (!busy) begin
      a_q     <= rs_val;
      b_q     <= rt_val;
      alu_out <= alu_res;
      if (SelectIns) ir <= instr;
      if (pc_load)   pc <= next_pc;
    end
  end

  // NOTE: the register file must come out of reset all-zero, so it is built
  // from resettable flops rather than an uninitialised RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (!busy && RegWrite && wr_idx != '0) begin
      regs[wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_mc_datapath_p.sv
// Self-checking bench: directed sequences, an ALU vector table and random
// ALU traffic compared against an arithmetic reference model.
module tb_mc_datapath_p;

  localparam logic [5:0] OPC = 6'h2b;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SelectIns, RegWrite, RegDst, ALUSrcA, MemRead, MemWrite;
  logic        MemtoReg, PCWrite, BEQ, BNE;
  logic [1:0]  ALUSrcB, PCSrc;
  logic [2:0]  ALUOp;
  logic [31:0] instr;

  logic        dmem_req, dmem_we, dmem_ack, alu_zero, busy;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, pc;
  logic [5:0]  opcode;

  logic        dmem_req16, dmem_we16, alu_zero16, busy16;
  logic        dmem_ack16 = 1'b1;
  logic [15:0] dmem_addr16, dmem_wdata16, pc16;
  logic [15:0] dmem_rdata16 = 16'h0000;
  logic [5:0]  opcode16;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  mc_datapath_p u_dut (
    .clk(clk), .rst_n(rst_n), .SelectIns(SelectIns), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .PCWrite(PCWrite), .BEQ(BEQ),
    .BNE(BNE), .PCSrc(PCSrc), .ALUOp(ALUOp), .instr(instr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .pc(pc), .opcode(opcode), .alu_zero(alu_zero), .busy(busy)
  );

  mc_datapath_p #(.DATA_W(16), .REG_N(8)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .SelectIns(SelectIns), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .PCWrite(PCWrite), .BEQ(BEQ),
    .BNE(BNE), .PCSrc(PCSrc), .ALUOp(ALUOp), .instr(instr),
    .dmem_req(dmem_req16), .dmem_we(dmem_we16), .dmem_addr(dmem_addr16),
    .dmem_wdata(dmem_wdata16), .dmem_rdata(dmem_rdata16), .dmem_ack(dmem_ack16),
    .pc(pc16), .opcode(opcode16), .alu_zero(alu_zero16), .busy(busy16)
  );

  typedef struct {
    logic [2:0]  op;
    logic [15:0] ia;
    logic [15:0] ib;
    logic [31:0] exp;
  } alu_vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clr();
    SelectIns = 0; RegWrite = 0; RegDst = 0; ALUSrcA = 0; ALUSrcB = 2'b00;
    MemRead = 0; MemWrite = 0; MemtoReg = 0; PCWrite = 0; BEQ = 0; BNE = 0;
    PCSrc = 2'b00; ALUOp = 3'd0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [15:0] imm);
    return {OPC, rs, rt, imm | {rd, 11'd0}};
  endfunction

  function automatic logic [63:0] sext16(input logic [15:0] v, input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return {{48{v[15]}}, v} & m;
  endfunction

  // Reference ALU on w-bit values, from the operation definitions.
  function automatic logic [63:0] model_alu(input int op, input logic [63:0] a,
                                            input logic [63:0] b, input int w);
    logic [63:0] m, r;
    longint      sa, sb;
    int          sh;
    m  = (64'd1 << w) - 64'd1;
    sa = $signed(a << (64 - w)) >>> (64 - w);
    sb = $signed(b << (64 - w)) >>> (64 - w);
    sh = int'(b % 64'(w));
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (sa < sb) ? 64'd1 : 64'd0;
      6: r = a << sh;
      default: r = (a & m) >> sh;
    endcase
    return r & m;
  endfunction

  // Write sign-extended imm into register t through ALUOut = r0 + imm.
  task automatic set_reg(input logic [4:0] t, input logic [15:0] imm);
    clr(); SelectIns = 1; instr = mk(5'd0, t, 5'd0, imm); cyc();
    clr(); ALUSrcA = 1; ALUSrcB = 2'b10; cyc(); cyc();
    clr(); RegWrite = 1; cyc(); clr();
  endtask

  task automatic load_ir(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    clr(); SelectIns = 1; instr = mk(rs, rt, rd, 16'h0000); cyc();
    clr(); cyc();
  endtask

  // Expose a register on pc via PCSrc=A.
  task automatic read_reg(input logic [4:0] r);
    load_ir(r, 5'd0, 5'd0);
    PCSrc = 2'b11; PCWrite = 1; cyc(); clr();
  endtask

  // Route ALU(rs, rt) straight into pc; returns alu_zero of both instances.
  task automatic do_alu(input logic [4:0] rs, input logic [4:0] rt, input logic [2:0] op,
                        output logic z, output logic z16);
    load_ir(rs, rt, 5'd0);
    ALUSrcA = 1; ALUOp = op; PCSrc = 2'b00; PCWrite = 1;
    #1; z = alu_zero; z16 = alu_zero16;
    cyc(); clr();
  endtask

  task automatic rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [2:0] op);
    load_ir(rs, rt, rd);
    ALUSrcA = 1; ALUOp = op; cyc();
    clr(); RegWrite = 1; RegDst = 1; cyc(); clr();
  endtask

  task automatic branch(input logic [4:0] rs, input logic [4:0] rt, input logic beq,
                        input logic bne, output logic z);
    load_ir(rs, rt, 5'd0);
    ALUSrcA = 1; ALUOp = 3'd1; PCSrc = 2'b11; BEQ = beq; BNE = bne;
    #1; z = alu_zero;
    cyc(); clr();
  endtask

  alu_vec_t   vecs[12];
  logic       z, z16;
  logic [15:0] ra, rb;
  logic [2:0] rop;
  logic [63:0] exp;

  initial begin
    vecs[0]  = '{3'd0, 16'h0007, 16'h0005, 32'h0000000C};
    vecs[1]  = '{3'd1, 16'h0007, 16'h0005, 32'h00000002};
    vecs[2]  = '{3'd1, 16'h0005, 16'h0007, 32'hFFFFFFFE};
    vecs[3]  = '{3'd2, 16'h00F0, 16'h0FF0, 32'h000000F0};
    vecs[4]  = '{3'd3, 16'h00F0, 16'h0F0F, 32'h00000FFF};
    vecs[5]  = '{3'd4, 16'hFFFF, 16'h00FF, 32'hFFFFFF00};
    vecs[6]  = '{3'd5, 16'hFFFF, 16'h0001, 32'h00000001};
    vecs[7]  = '{3'd5, 16'h0001, 16'hFFFF, 32'h00000000};
    vecs[8]  = '{3'd6, 16'h0001, 16'd31,   32'h80000000};
    vecs[9]  = '{3'd6, 16'h0003, 16'd33,   32'h00000006};
    vecs[10] = '{3'd7, 16'hFFFF, 16'd28,   32'h0000000F};
    vecs[11] = '{3'd0, 16'h7FFF, 16'h7FFF, 32'h0000FFFE};

    clr(); instr = '0; rst_n = 0; dmem_ack = 0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_pc", pc, 64'd0);
    check("reset_busy", busy, 64'd0);
    check("reset_req", dmem_req, 64'd0);
    @(negedge clk) rst_n = 1;

    // PC increment through the ALU.
    ALUSrcB = 2'b01; PCWrite = 1;
    cyc(); check("pc_inc_1", pc, 64'd4); check("pc16_inc_1", pc16, 64'd4);
    cyc(); check("pc_inc_2", pc, 64'd8);
    clr();

    // Mid-cycle asynchronous reset.
    cyc(); #2 rst_n = 0; #1;
    check("async_pc", pc, 64'd0);
    check("async_busy", busy, 64'd0);
    @(negedge clk) rst_n = 1;

    // R-type and the zero register.
    set_reg(5'd1, 16'd7); set_reg(5'd2, 16'd5);
    check("opcode", opcode, 64'(OPC));
    rtype(5'd1, 5'd2, 5'd3, 3'd1);
    read_reg(5'd3); check("rtype_r3", pc, 64'd2);
    rtype(5'd1, 5'd2, 5'd0, 3'd1);
    read_reg(5'd0); check("rtype_r0", pc, 64'd0);

    // Branches.
    set_reg(5'd4, 16'd9); set_reg(5'd5, 16'd9); set_reg(5'd6, 16'd8);
    read_reg(5'd0);
    branch(5'd4, 5'd5, 1'b1, 1'b0, z);
    check("beq_eq_zero", z, 64'd1); check("beq_eq_pc", pc, 64'd9);
    read_reg(5'd0);
    branch(5'd4, 5'd6, 1'b1, 1'b0, z);
    check("beq_ne_zero", z, 64'd0); check("beq_ne_pc", pc, 64'd0);
    branch(5'd4, 5'd6, 1'b0, 1'b1, z);
    check("bne_ne_pc", pc, 64'd9);
    read_reg(5'd0);
    branch(5'd4, 5'd5, 1'b0, 1'b1, z);
    check("bne_eq_pc", pc, 64'd0);

    // Narrow instance: wrap, signed compare, register index folding.
    set_reg(5'd1, 16'hFFFF); set_reg(5'd2, 16'h0001);
    do_alu(5'd1, 5'd2, 3'd0, z, z16);
    check("w16_add_pc", pc16, 64'd0); check("w16_add_zero", z16, 64'd1);
    check("w32_add_zero", z, 64'd1);
    do_alu(5'd1, 5'd2, 3'd5, z, z16);
    check("w16_slt", pc16, 64'd1);
    set_reg(5'd1, 16'h0011);
    rtype(5'd1, 5'd2, 5'd9, 3'd0);
    read_reg(5'd1);
    check("w16_rd9_r1", pc16, 64'h12); check("w32_r1_kept", pc, 64'h11);

    // ALU vector table through the full datapath.
    foreach (vecs[i]) begin
      set_reg(5'd1, vecs[i].ia); set_reg(5'd2, vecs[i].ib);
      do_alu(5'd1, 5'd2, vecs[i].op, z, z16);
      check($sformatf("vec%0d", i), pc, 64'(vecs[i].exp));
    end

    // Random ALU traffic against the reference model, both widths.
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rop = 3'($urandom_range(0, 7));
      set_reg(5'd1, ra); set_reg(5'd2, rb);
      do_alu(5'd1, 5'd2, rop, z, z16);
      exp = model_alu(int'(rop), sext16(ra, 32), sext16(rb, 32), 32);
      check($sformatf("rand%0d_op%0d", i, rop), pc, exp);
      check($sformatf("rand%0d_zero", i), z, 64'(exp == 0));
      check($sformatf("rand%0d_w16", i), pc16,
            model_alu(int'(rop), sext16(ra, 16), sext16(rb, 16), 16));
    end

    // Load with three wait cycles; PC must stay frozen.
    read_reg(5'd0);
    clr(); SelectIns = 1; instr = mk(5'd0, 5'd7, 5'd0, 16'h0040); cyc();
    clr(); ALUSrcA = 1; ALUSrcB = 2'b10; cyc(); cyc();
    MemRead = 1; cyc(); clr();
    check("ld_we", dmem_we, 64'd0);
    for (int k = 0; k < 3; k++) begin
      MemRead = 1; PCWrite = 1; ALUSrcB = 2'b01;
      dmem_ack = (k == 2); dmem_rdata = 32'hDEADBEEF;
      #1;
      check($sformatf("ld_req_%0d", k), dmem_req, 64'd1);
      check($sformatf("ld_addr_%0d", k), dmem_addr, 64'h40);
      check($sformatf("ld_busy_%0d", k), busy, 64'd1);
      check($sformatf("ld_pc_%0d", k), pc, 64'd0);
      cyc();
    end
    dmem_ack = 0; clr();
    check("ld_req_done", dmem_req, 64'd0);
    check("ld_busy_done", busy, 64'd0);
    RegWrite = 1; MemtoReg = 1; cyc(); clr();
    read_reg(5'd7); check("ld_rt", pc, 64'hDEADBEEF);

    // Store aborted by reset.
    set_reg(5'd8, 16'h0123);
    clr(); SelectIns = 1; instr = mk(5'd0, 5'd8, 5'd0, 16'h0080); cyc();
    clr(); ALUSrcA = 1; ALUSrcB = 2'b10; cyc(); cyc();
    MemWrite = 1; cyc(); clr();
    check("st_req", dmem_req, 64'd1); check("st_we", dmem_we, 64'd1);
    check("st_addr", dmem_addr, 64'h80); check("st_wdata", dmem_wdata, 64'h123);
    cyc(); #2 rst_n = 0; #1;
    check("abort_req", dmem_req, 64'd0); check("abort_busy", busy, 64'd0);
    check("abort_addr", dmem_addr, 64'd0);
    @(negedge clk) rst_n = 1;
    dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
    for (int k = 0; k < 3; k++) begin
      cyc(); check($sformatf("abort_idle_%0d", k), dmem_req, 64'd0);
    end
    dmem_ack = 0;
    clr(); SelectIns = 1; instr = mk(5'd0, 5'd9, 5'd0, 16'h0000); cyc();
    clr(); RegWrite = 1; MemtoReg = 1; cyc(); clr();
    read_reg(5'd9); check("abort_mdr", pc, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mc_datapath_p.md
MC_DATAPATH_P -- requirements
Module: mc_datapath_p

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning datapath/register width (legal 16..64).
REQ-002 SHALL have parameter REG_N, default 16, meaning register count (power of two, 2..32); RA_W = log2(REG_N).
REQ-003 SHALL have parameter RESET_PC, default 0, meaning PC value after reset.
REQ-004 SHALL have parameter PC_INC, default 4, meaning the ALUSrcB=01 constant.
REQ-005 SHALL have ports: clk  in  1  clock, all state updates on the rising edge.
REQ-006 SHALL have rst_n  in  1  reset, asynchronous, active-low; one clock only.
REQ-007 SHALL have control inputs, 1 bit each unless stated: SelectIns (IR load), RegWrite, RegDst, ALUSrcA, ALUSrcB[1:0], MemRead, MemWrite, MemtoReg, PCWrite, BEQ, BNE, PCSrc[1:0], ALUOp[2:0].
REQ-008 SHALL have instr  in  32  instruction word: op[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0], jt[25:0].
REQ-009 SHALL have dmem_req out 1, dmem_we out 1, dmem_addr out DATA_W, dmem_wdata out DATA_W, dmem_rdata in DATA_W, dmem_ack in 1.
REQ-010 SHALL have outputs pc DATA_W, opcode 6 (IR[31:26]), alu_zero 1, busy 1.

Function
REQ-011 SHALL hold PC, IR, A, B, ALUOut, MDR and a REG_N x DATA_W register file; register indices use the low RA_W bits of rs/rt/rd.
REQ-012 SHALL drive ALU input A = ALUSrcA ? A : PC.
REQ-013 SHALL drive ALU input B = B (00), PC_INC (01), sign-extended imm (10), sign-extended imm<<2 (11), truncated/extended to DATA_W.
REQ-014 SHALL compute by ALUOp: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT signed (result 1/0), 6 SLL by B[log2(DATA_W)-1:0], 7 SRL likewise; all modulo 2^DATA_W.
REQ-015 SHALL output alu_zero combinationally, 1 when ALU result == 0.
REQ-016 SHALL load ALUOut with the ALU result and A/B from regfile[rs]/regfile[rt] every non-stalled cycle; a same-cycle regfile write is not bypassed, so A/B receive the old value.
REQ-017 SHALL load IR from instr when SelectIns=1 and not stalled.
REQ-018 SHALL select next PC: PCSrc 00 ALU result, 01 ALUOut, 10 {PC[DATA_W-1:28], jt, 2'b00} truncated to DATA_W, 11 A.
REQ-019 SHALL load PC when not stalled and (PCWrite | (BEQ & alu_zero) | (BNE & ~alu_zero)).
REQ-020 SHALL write regfile[RegDst ? rd : rt] with (MemtoReg ? MDR : ALUOut) when RegWrite=1 and not stalled; writes to register 0 are discarded, and register 0 reads as 0.
REQ-021 SHALL, when MemRead or MemWrite is 1 with busy=0, register dmem_req=1, dmem_we=MemWrite, dmem_addr=ALUOut, dmem_wdata=B, and set busy=1 from the next cycle.
REQ-022 SHALL treat MemRead and MemWrite asserted together as a write.
REQ-023 SHALL hold dmem_req and dmem_addr/wdata/we stable until a cycle with dmem_ack=1; in that cycle MDR loads dmem_rdata if reading, and dmem_req and busy clear on the next edge.
REQ-024 SHALL ignore dmem_ack while dmem_req=0.
REQ-025 SHALL, while busy=1, suppress every state update except MDR capture, ignore all control inputs, and ignore new MemRead/MemWrite requests; minimum access latency is 2 cycles (issue, ack).

Reset
REQ-026 SHALL on rst_n=0 set PC=RESET_PC, set IR/A/B/ALUOut/MDR=0, all registers=0, dmem_req=0, dmem_we=0, busy=0, dmem_addr/wdata=0, asynchronously.
REQ-027 SHALL abandon an outstanding memory access when reset is asserted mid-transaction, with no MDR or regfile update.

Structure
REQ-028 SHALL place ALUOp codes, ALUSrcB/PCSrc encodings and instruction field positions in shared package mc_pkg.
REQ-029 SHALL implement the ALU as sub-module mc_alu (parameter DATA_W, combinational, outputs result and zero).

Verification
REQ-030 SHALL cover reset: rst_n low mid-cycle -> pc=RESET_PC and busy=0 immediately; with PC_INC=4, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSrc=00, PCWrite=1 -> pc=4, then pc=8.
REQ-031 SHALL cover R-type: r1=7, r2=5, IR rs=1 rt=2 rd=3, SUB, RegDst=1, RegWrite=1 -> r3=2; same sequence with rd=0 -> r0 still reads 0.
REQ-032 SHALL cover branches: A=B=9 with SUB and BEQ=1 -> PC updated; A=9, B=8 with BEQ=1 -> PC held; BNE=1 -> PC updated.
REQ-033 SHALL cover load with wait states: MemRead at ALUOut=0x40, dmem_ack after 3 cycles with rdata=0xDEADBEEF -> dmem_req held 3 cycles, addr 0x40 stable, busy=1, PC frozen despite PCWrite=1; then MemtoReg write gives rt=0xDEADBEEF.
REQ-034 SHALL cover abort: rst_n asserted during an outstanding store -> dmem_req=0 at once, MDR=0, no further request.
REQ-035 SHALL cover width: DATA_W=16, REG_N=8 -> ADD 0xFFFF+1=0 with alu_zero=1; SLT -1<1 gives 1; rd=9 maps to r1.
